// File: rtl/chacha_avalon_host_if.sv
// chacha_avalon_host_if: command/response stream and Avalon-MM host signals of the ChaCha register sequencer.
interface chacha_avalon_host_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              iCmd_valid;
  logic              oCmd_ready;
  logic              iCmd_write;
  logic              iCmd_poll;
  logic [ADDR_W-1:0] iCmd_address;
  logic [DATA_W-1:0] iCmd_wdata;
  logic              oRsp_valid;
  logic              iRsp_ready;
  logic [DATA_W-1:0] oRsp_data;
  logic              oRsp_timeout;
  logic              oChipselect;
  logic              oWrite;
  logic              oRead;
  logic [ADDR_W-1:0] oAddress;
  logic [DATA_W-1:0] oWrite_data;
  logic [DATA_W-1:0] iRead_data;
  modport master (
    input  iCmd_valid, iCmd_write, iCmd_poll, iCmd_address, iCmd_wdata, iRsp_ready, iRead_data,
    output oCmd_ready, oRsp_valid, oRsp_data, oRsp_timeout, oChipselect, oWrite, oRead, oAddress, oWrite_data
  );
  modport slave (
    output iCmd_valid, iCmd_write, iCmd_poll, iCmd_address, iCmd_wdata, iRsp_ready, iRead_data,
    input  oCmd_ready, oRsp_valid, oRsp_data, oRsp_timeout, oChipselect, oWrite, oRead, oAddress, oWrite_data
  );
endinterface

// File: rtl/chacha_avalon_host.sv
// chacha_avalon_host: turns write/read/poll commands into single-cycle Avalon-MM strobes, one outstanding.
// Poll commands (masked repeated reads with timeout) are compiled in by CHACHA_HOST_POLL_EN.
module chacha_avalon_host #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int POLL_MAX     = 1024,
  parameter int POLL_GAP     = 4
) (
  input logic iClk,
  input logic iReset_n,
  chacha_avalon_host_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, ACCESS, WAIT, RESP
`ifdef CHACHA_HOST_POLL_EN
    , GAP
`endif
  } state_e;
  state_e state_q, state_d;
  logic wr_q, wr_d, ready_q, we_q, re_q, rv_q, smp;
  logic [1:0] lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic cmd_poll;
`ifdef CHACHA_HOST_POLL_EN
  localparam int AW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  logic poll_q, poll_d, tmo_q, tmo_d;
  logic [AW-1:0] att_q, att_d;
  logic [GW-1:0] gap_q, gap_d;
  assign cmd_poll = bus.iCmd_poll;
  assign bus.oRsp_timeout = tmo_q;
`else
  logic unused_poll;
  assign cmd_poll = 1'b0;
  assign unused_poll = ^{bus.iCmd_poll, POLL_MAX[0], POLL_GAP[0]};
  assign bus.oRsp_timeout = 1'b0;
`endif
  assign bus.oCmd_ready  = ready_q;
  assign bus.oRsp_valid  = rv_q;
  assign bus.oRsp_data   = rdata_q;
  assign bus.oWrite      = we_q;
  assign bus.oRead       = re_q;
  assign bus.oChipselect = we_q | re_q;
  assign bus.oAddress    = addr_q;
  assign bus.oWrite_data = wdata_q;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lat_d = lat_q;
    smp = 1'b0;
`ifdef CHACHA_HOST_POLL_EN
    poll_d = poll_q;
    tmo_d = tmo_q;
    att_d = att_q;
    gap_d = gap_q;
`endif
    case (state_q)
      IDLE: if (bus.iCmd_valid && ready_q) begin
        state_d = ACCESS;
        wr_d = bus.iCmd_write & ~cmd_poll;
        addr_d = bus.iCmd_address;
        wdata_d = bus.iCmd_wdata;
`ifdef CHACHA_HOST_POLL_EN
        poll_d = cmd_poll;
        att_d = '0;
`endif
      end
      ACCESS: begin
        state_d = wr_q ? IDLE : WAIT;
        lat_d = 2'd1;
        smp = !wr_q && READ_LATENCY == 0;
      end
      WAIT: begin
        smp = lat_q == 2'(READ_LATENCY);
        lat_d = lat_q + 2'd1;
      end
      RESP: state_d = bus.iRsp_ready ? IDLE : RESP;
`ifdef CHACHA_HOST_POLL_EN
      GAP: begin
        state_d = gap_q == GW'(POLL_GAP) ? ACCESS : GAP;
        gap_d = gap_q + GW'(1);
      end
`endif
      default: state_d = IDLE;
    endcase
    // iRead_data is valid exactly on the edge ending strobe cycle + READ_LATENCY
    if (smp) begin
      state_d = RESP;
      rdata_d = bus.iRead_data;
`ifdef CHACHA_HOST_POLL_EN
      tmo_d = 1'b0;
      if (poll_q) begin
        att_d = att_q + AW'(1);
        if ((bus.iRead_data & wdata_q) == '0) begin
          tmo_d = att_d == AW'(POLL_MAX);
          state_d = tmo_d ? RESP : GAP;
          gap_d = GW'(1);
        end
      end
`endif
    end
  end
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= IDLE;
      {wr_q, ready_q, we_q, re_q, rv_q} <= '0;
      lat_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      lat_q <= lat_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= state_d == IDLE;
      we_q <= state_d == ACCESS && wr_d;
      re_q <= state_d == ACCESS && !wr_d;
      rv_q <= state_d == RESP;
    end
  end
`ifdef CHACHA_HOST_POLL_EN
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      {poll_q, tmo_q} <= '0;
      att_q <= '0;
      gap_q <= '0;
    end else begin
      poll_q <= poll_d;
      tmo_q <= tmo_d;
      att_q <= att_d;
      gap_q <= gap_d;
    end
  end
`endif
endmodule

// File: tb/tb_chacha_avalon_host.sv
// tb_chacha_avalon_host: scoreboard bench for the Avalon host sequencer with a latency-1 register slave model.
module tb_chacha_avalon_host;
  typedef struct packed {logic w; logic [7:0] a; logic [31:0] d;} stb_t;
  typedef struct packed {logic [31:0] d; logic t;} rsp_t;
  logic iClk = 1'b0;
  logic iReset_n = 1'b0;
  int vectors = 0, errors = 0, cyc = 0;
  int rd_seen = 0, rd_used = 0;
  stb_t exp_stb[$];
  rsp_t exp_rsp[$];
  logic [31:0] rd_vals[$];
  int stb_log[$];
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;
  chacha_avalon_host_if #(.ADDR_W(8), .DATA_W(32)) bus();
  chacha_avalon_host #(
    .ADDR_W(8), .DATA_W(32), .READ_LATENCY(1), .POLL_MAX(8), .POLL_GAP(4)
  ) dut (
    .iClk(iClk),
    .iReset_n(iReset_n),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask
  // slave answers one cycle after the strobe; outside that window it drives a junk pattern
  always @(posedge iClk) begin
    #1;
    bus.iRead_data = (rd_seen != rd_used) ? rd_vals[rd_used] : 32'hA5A5A5A5;
    if (rd_seen != rd_used) rd_used++;
  end
  always @(negedge iClk) begin
    stb_t e;
    rsp_t r;
    if (bus.oChipselect || bus.oRead || bus.oWrite) begin
      check("stb_excl", bus.oRead & bus.oWrite, 0);
      check("stb_cs", bus.oChipselect, bus.oRead | bus.oWrite);
      check("stb_pending", exp_stb.size() != 0, 1);
      stb_log.push_back(cyc);
      if (bus.oRead) rd_seen++;
      if (exp_stb.size() != 0) begin
        e = exp_stb.pop_front();
        check("stb_type", bus.oWrite, e.w);
        check("stb_addr", bus.oAddress, e.a);
        if (e.w) check("stb_wdata", bus.oWrite_data, e.d);
      end
    end
    if (bus.oRsp_valid && bus.iRsp_ready) begin
      check("rsp_pending", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) begin
        r = exp_rsp.pop_front();
        check("rsp_data", bus.oRsp_data, r.d);
        check("rsp_timeout", bus.oRsp_timeout, r.t);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask
  task automatic send(input logic w, input logic p, input logic [7:0] a, input logic [31:0] d, output int c);
    int n = 0;
    bus.iCmd_valid = 1'b1;
    bus.iCmd_write = w;
    bus.iCmd_poll = p;
    bus.iCmd_address = a;
    bus.iCmd_wdata = d;
    @(negedge iClk);
    while (!bus.oCmd_ready && n < 50) begin
      @(negedge iClk);
      n++;
    end
    check("cmd_accept", bus.oCmd_ready, 1);
    c = cyc;
    tick(1);
  endtask
  task automatic wait_rsp(output int c);
    int n = 0;
    @(negedge iClk);
    while (!bus.oRsp_valid && n < 200) begin
      @(negedge iClk);
      n++;
    end
    check("rsp_arrive", bus.oRsp_valid, 1);
    c = cyc;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c, r, n0, cnt;
    logic w[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int gaps[3] = '{2, 2, 4};
    logic [31:0] d;
    bus.iCmd_valid = 1'b0;
    bus.iCmd_write = 1'b0;
    bus.iCmd_poll = 1'b0;
    bus.iCmd_address = '0;
    bus.iCmd_wdata = '0;
    bus.iRsp_ready = 1'b0;
    tick(3);
    @(negedge iClk);
    check("rst_ctrl", {bus.oCmd_ready, bus.oRsp_valid, bus.oRsp_timeout, bus.oChipselect, bus.oWrite, bus.oRead}, 0);
    check("rst_addr", bus.oAddress, 0);
    check("rst_wdata", bus.oWrite_data, 0);
    check("rst_rdata", bus.oRsp_data, 0);
    tick(1);
    iReset_n = 1'b1;
    @(negedge iClk);
    check("rst_ready_hold", bus.oCmd_ready, 0);
    @(negedge iClk);
    check("rst_ready_rise", bus.oCmd_ready, 1);
    tick(1);
    // single write
    exp_stb.push_back(stb_t'{1'b1, 8'h08, 32'hDEADBEEF});
    send(1'b1, 1'b0, 8'h08, 32'hDEADBEEF, c);
    bus.iCmd_valid = 1'b0;
    @(negedge iClk);
    check("wr_busy", bus.oCmd_ready, 0);
    @(negedge iClk);
    check("wr_ready_back", bus.oCmd_ready, 1);
    check("wr_stb_cyc", stb_log[$], c + 1);
    check("wr_no_rsp", bus.oRsp_valid, 0);
    tick(2);
    // read held under backpressure
    rd_vals.push_back(32'h12345678);
    exp_stb.push_back(stb_t'{1'b0, 8'h40, 32'h0});
    exp_rsp.push_back(rsp_t'{32'h12345678, 1'b0});
    send(1'b0, 1'b0, 8'h40, 32'h0, c);
    bus.iCmd_valid = 1'b0;
    wait_rsp(r);
    check("rd_lat", r - c, 3);
    for (int i = 0; i < 5; i++) begin
      check("rd_hold_valid", bus.oRsp_valid, 1);
      check("rd_hold_data", {bus.oRsp_timeout, bus.oRsp_data}, {1'b0, 32'h12345678});
      @(negedge iClk);
    end
    tick(1);
    bus.iRsp_ready = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    check("rd_rsp_drop", bus.oRsp_valid, 0);
    check("rd_idle_ready", bus.oCmd_ready, 1);
    tick(1);
    // back-to-back with iCmd_valid held
    n0 = stb_log.size();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      exp_stb.push_back(stb_t'{w[i], 8'h10 + 8'(i), d});
      if (!w[i]) begin
        rd_vals.push_back(32'hCAFE0001);
        exp_rsp.push_back(rsp_t'{32'hCAFE0001, 1'b0});
      end
      send(w[i], 1'b0, 8'h10 + 8'(i), d, c);
    end
    bus.iCmd_valid = 1'b0;
    tick(8);
    check("b2b_count", stb_log.size() - n0, 4);
    for (int i = 0; i < 3; i++) check("b2b_gap", stb_log[n0 + i + 1] - stb_log[n0 + i], gaps[i]);
    // reset while waiting for read data
    rd_vals.push_back(32'h0BAD0BAD);
    exp_stb.push_back(stb_t'{1'b0, 8'h44, 32'h0});
    send(1'b0, 1'b0, 8'h44, 32'h0, c);
    bus.iCmd_valid = 1'b0;
    tick(1);
    iReset_n = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    check("mid_rst_quiet", {bus.oChipselect, bus.oWrite, bus.oRead, bus.oRsp_valid, bus.oCmd_ready}, 0);
    tick(1);
    iReset_n = 1'b1;
    @(negedge iClk);
    check("mid_rst_ready_hold", bus.oCmd_ready, 0);
    @(negedge iClk);
    check("mid_rst_ready", bus.oCmd_ready, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      if (bus.oRsp_valid) cnt++;
    end
    check("mid_rst_no_rsp", cnt, 0);
    tick(1);
`ifdef CHACHA_HOST_POLL_EN
    // poll that matches on the fourth read
    n0 = stb_log.size();
    for (int i = 0; i < 4; i++) begin
      rd_vals.push_back(i == 3 ? 32'h2 : 32'h0);
      exp_stb.push_back(stb_t'{1'b0, 8'h00, 32'h0});
    end
    exp_rsp.push_back(rsp_t'{32'h2, 1'b0});
    send(1'b0, 1'b1, 8'h00, 32'h2, c);
    bus.iCmd_valid = 1'b0;
    wait_rsp(r);
    tick(4);
    check("poll_count", stb_log.size() - n0, 4);
    check("poll_first", stb_log[n0], c + 1);
    for (int i = 1; i < 4; i++) check("poll_gap", stb_log[n0 + i] - stb_log[n0 + i - 1], 6);
    check("poll_rsp_lat", r, stb_log[n0 + 3] + 2);
    // zero mask never matches; write bit must not override poll
    n0 = stb_log.size();
    for (int i = 0; i < 8; i++) begin
      rd_vals.push_back(32'h101 + 32'(i));
      exp_stb.push_back(stb_t'{1'b0, 8'h04, 32'h0});
    end
    exp_rsp.push_back(rsp_t'{32'h108, 1'b1});
    send(1'b1, 1'b1, 8'h04, 32'h0, c);
    bus.iCmd_valid = 1'b0;
    wait_rsp(r);
    tick(10);
    check("poll_to_count", stb_log.size() - n0, 8);
`endif
    tick(3);
    check("stb_leftover", exp_stb.size(), 0);
    check("rsp_leftover", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/chacha_avalon_host.md
# chacha_avalon_host

Avalon-MM host (initiator) sequencer that drives the register port of the ChaCha accelerator's Avalon slave wrapper from a simple command/response stream. It is the other end of that slave interface: firmware-less test harnesses and the on-chip DMA path push write, read or poll commands, and the block turns them into single-cycle Avalon strobes with fixed-latency read capture. One transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 8, Avalon address width
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from read strobe to valid iRead_data (legal 0..3)
- POLL_MAX, 1024, max reads per poll command (POLL_EN only)
- POLL_GAP, 4, idle cycles between poll reads (POLL_EN only, ≥1)

Ports (one clock; reset is synchronous and active-low):
- iClk  in  1  clock
- iReset_n  in  1  synchronous active-low reset
- iCmd_valid  in  1  command present
- oCmd_ready  out  1  command accepted when valid&ready
- iCmd_write  in  1  1 = write, 0 = read
- iCmd_poll  in  1  1 = poll (overrides iCmd_write); ignored without POLL_EN
- iCmd_address  in  ADDR_W  target register
- iCmd_wdata  in  DATA_W  write data; poll mask for poll commands
- oRsp_valid  out  1  response present
- iRsp_ready  in  1  response consumed when valid&ready
- oRsp_data  out  DATA_W  read/poll data
- oRsp_timeout  out  1  poll ended without match
- oChipselect  out  1  Avalon chipselect
- oWrite  out  1  Avalon write strobe
- oRead  out  1  Avalon read strobe
- oAddress  out  ADDR_W  Avalon address
- oWrite_data  out  DATA_W  Avalon write data
- iRead_data  in  DATA_W  Avalon read data

## Operation
- All outputs registered. States: IDLE, ACCESS, WAIT, GAP, RESP.
- IDLE: oCmd_ready=1. On accept latch address, wdata/mask, type; go ACCESS.
- ACCESS (1 cycle): oChipselect=1 with exactly one of oWrite/oRead; oAddress/oWrite_data = latched values. Write → IDLE (no response). Read/poll → WAIT (or direct sample if READ_LATENCY=0).
- WAIT: counter runs READ_LATENCY cycles; iRead_data sampled at edge ending cycle T+READ_LATENCY (T = strobe cycle).
- Read: sampled data → oRsp_data, oRsp_timeout=0, go RESP.
- Poll: attempt counter (clog2(POLL_MAX+1) bits) increments per sample. (data & mask)≠0 → RESP, timeout=0. Else attempts==POLL_MAX → RESP with last data, timeout=1. Else GAP for POLL_GAP cycles then ACCESS (read again).
- RESP: oRsp_valid=1, oRsp_data/oRsp_timeout stable until iRsp_ready; on handshake → IDLE.
- oWrite and oRead never both 1; oChipselect = oWrite|oRead. oAddress/oWrite_data hold last value outside ACCESS.
- Mask 0 on poll: never matches; runs to timeout.

## Timing
- Reset: state IDLE; oCmd_ready, oRsp_valid, oRsp_timeout, oChipselect, oWrite, oRead = 0; oAddress, oWrite_data, oRsp_data = 0; counters 0. oCmd_ready rises the first cycle after iReset_n returns high.
- Write: accept at edge k → strobe cycle k+1 → oCmd_ready high cycle k+2. Max rate one write per 2 cycles.
- Read: accept edge k → strobe k+1 → oRsp_valid from cycle k+2+READ_LATENCY.
- Poll attempt period: 1 + READ_LATENCY + POLL_GAP cycles.
- oCmd_ready=0 in every state except IDLE; commands presented meanwhile are not taken.
- Reset mid-transaction: at the reset edge strobes drop, pending response and poll state discarded; no partial response ever emitted.
- iRsp_ready held high: response lasts exactly one cycle, IDLE next cycle.

## Configuration
- CHACHA_HOST_POLL_EN defined: poll command, attempt/gap counters, GAP state and oRsp_timeout logic compiled in.
- Undefined: iCmd_poll ignored (treated as 0), GAP state absent, oRsp_timeout tied 0; POLL_MAX/POLL_GAP unused.

## Test plan
- Reset then write 0x08 ← 0xDEADBEEF: one cycle cs=1, write=1, address 0x08, data 0xDEADBEEF; oCmd_ready back high 2 cycles after accept; no oRsp_valid.
- Read 0x40, model returns 0x12345678 at READ_LATENCY=1: oRsp_valid exactly 3 cycles after accept, data 0x12345678, timeout 0; held 5 cycles under iRsp_ready=0.
- Back-to-back commands with iCmd_valid held: writes spaced 2 cycles, oRead/oWrite never concurrent, no command lost or duplicated.
- Poll 0x00 mask 0x2, model returns 0x0 three times then 0x2: four read strobes spaced 1+1+4=6 cycles, response 0x2, timeout 0 (POLL_EN).
- Poll mask 0x0 with POLL_MAX=8: exactly 8 reads, oRsp_timeout=1, data = last read value.
- iReset_n low during WAIT of a read: strobes and oRsp_valid 0 next cycle, no response after release, oCmd_ready=1 the cycle after release.
